// File: rtl/use_stream_pkg.sv
// use_stream_pkg: shared sizing, FSM states and byte type
// for the use-stream collector.
package use_stream_pkg;
  localparam int DEF_NUM_ELEMENTS = 4;
  localparam int DEF_BUS_BYTES    = 8;
  localparam int DEF_MAX_VAR_LEN  = 16;
  localparam int DEF_FIXED_LEN    = 'h11;

  function automatic int use_bytes(
    input int var_len,
    input int fixed_len
  );
    return var_len + fixed_len + 1;
  endfunction

  localparam int MAX_USE_BYTES =
    use_bytes(DEF_MAX_VAR_LEN, DEF_FIXED_LEN);
  localparam int LEN_W = $clog2(MAX_USE_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    PACK,
    FLUSH
  } state_t;

  typedef logic [7:0] byteReg;
endpackage

// File: rtl/use_stream_collector_byte_packer.sv
// byte_packer: 2W-byte accumulator feeding a registered
// AXI4-Stream beat; full beats first, partial beat on flush.
module byte_packer
  import use_stream_pkg::*;
#(
  parameter int W = DEF_BUS_BYTES,
  localparam int CNT_W = $clog2(2 * W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W*8-1:0]   i_data,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_in_ready,
  input  logic             i_flush,
  output logic             o_flush_done,
  output logic [W*8-1:0]   m_axis_tdata,
  output logic [W-1:0]     m_axis_tkeep,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);
  localparam logic [CNT_W-1:0] WC = CNT_W'(W);

  byteReg r_acc [2*W];
  byteReg w_acc [2*W];
  logic [CNT_W-1:0] r_cnt, w_cnt, w_base, w_idx;
  logic [W*8-1:0] r_data;
  logic [W-1:0] r_keep;
  logic r_valid, r_last;
  logic w_free, w_emit, w_fl_emit;

  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = r_keep;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tlast  = r_last;

  always_comb begin
    w_free = !r_valid || m_axis_tready;
    w_emit = (r_cnt >= WC) && w_free;
    w_base = w_emit ? r_cnt - WC : r_cnt;
    o_in_ready = w_base < WC;
    w_fl_emit = i_flush && !w_emit && (r_cnt != '0) && w_free;
    o_flush_done = i_flush && !w_emit && ((r_cnt == '0) || w_free);
    w_acc = r_acc;
    w_cnt = w_base;
    w_idx = '0;
    if (w_emit) begin
      for (int k = 0; k < W; k++) begin
        w_acc[k]     = r_acc[k+W];
        w_acc[k+W]   = 8'h00;
      end
    end
    // new bytes land just above whatever survives this cycle's emission
    if (o_in_ready) begin
      for (int j = 0; j < W; j++) begin
        w_idx = w_base + CNT_W'(j);
        if (CNT_W'(j) < i_cnt) w_acc[w_idx] = i_data[j*8 +: 8];
      end
      w_cnt = w_base + i_cnt;
    end
    if (w_fl_emit) w_cnt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2 * W; k++) r_acc[k] <= 8'h00;
      r_cnt   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_acc <= w_acc;
      r_cnt <= w_cnt;
      if (w_emit) begin
        r_valid <= 1'b1;
        r_last  <= 1'b0;
        r_keep  <= '1;
        for (int k = 0; k < W; k++) r_data[k*8 +: 8] <= r_acc[k];
      end else if (w_fl_emit) begin
        r_valid <= 1'b1;
        r_last  <= 1'b1;
        for (int k = 0; k < W; k++) begin
          r_keep[k] <= CNT_W'(k) < r_cnt;
          r_data[k*8 +: 8] <= (CNT_W'(k) < r_cnt) ? r_acc[k] : 8'h00;
        end
      end else if (m_axis_tready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/use_stream_collector.sv
// use_stream_collector: drains ring-ordered use records and
// packs their bytes back-to-back onto an AXI4-Stream master.
module use_stream_collector
  import use_stream_pkg::*;
#(
  parameter int NUM_ELEMENTS             = DEF_NUM_ELEMENTS,
  parameter int DATA_BUS_WIDTH_BYTES     = DEF_BUS_BYTES,
  parameter int MAX_VARIABLEFIELD_LENGTH = DEF_MAX_VAR_LEN,
  parameter int FIXEDFIELD_LENGTH_BYTES  = DEF_FIXED_LEN,
  localparam int REC_BYTES =
    use_bytes(MAX_VARIABLEFIELD_LENGTH, FIXEDFIELD_LENGTH_BYTES),
  localparam int REC_LEN_W = $clog2(REC_BYTES),
  localparam int W = DATA_BUS_WIDTH_BYTES
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_ELEMENTS*REC_BYTES*8-1:0] use_data_in,
  input  logic [NUM_ELEMENTS*REC_LEN_W-1:0]   use_len_in,
  input  logic [NUM_ELEMENTS-1:0]             use_ready_in,
  output logic [NUM_ELEMENTS-1:0]             use_ack_out,
  input  logic                                flush_in,
  output logic [W*8-1:0]                      m_axis_tdata,
  output logic [W-1:0]                        m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast
);
  localparam int CNT_W = $clog2(2 * W);
  localparam int IDX_W =
    (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEMENTS - 1);
  localparam logic [REC_LEN_W-1:0] REM_MAX = REC_LEN_W'(REC_BYTES);
  localparam logic [REC_LEN_W-1:0] REM_W = REC_LEN_W'(W);

  state_t r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  byteReg r_rec [REC_BYTES];
  byteReg w_rec_ext [REC_BYTES+W];
  logic [REC_LEN_W-1:0] r_rem, w_raw_len, w_len;
  logic r_flush_pend;
  logic [NUM_ELEMENTS-1:0] r_ack;
  logic [W*8-1:0] w_bytes;
  logic [CNT_W-1:0] w_cnt;
  logic w_in_ready, w_flush_done, w_take, w_pack, w_flush;

  assign use_ack_out = r_ack;
  assign w_raw_len = use_len_in[int'(r_idx)*REC_LEN_W +: REC_LEN_W];
  assign w_len = (w_raw_len > REM_MAX) ? REM_MAX : w_raw_len;
  assign w_pack = (r_state == PACK);
  assign w_flush = (r_state == FLUSH);
  assign w_take = w_pack && w_in_ready;
  assign w_cnt = !w_pack ? '0 :
                 (r_rem < REM_W) ? CNT_W'(r_rem) : CNT_W'(W);

  always_comb begin
    for (int b = 0; b < REC_BYTES + W; b++) w_rec_ext[b] = 8'h00;
    for (int b = 0; b < REC_BYTES; b++) w_rec_ext[b] = r_rec[b];
    w_bytes = '0;
    for (int j = 0; j < W; j++) w_bytes[j*8 +: 8] = w_rec_ext[j];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // a pending flush blocks new records so it closes the right packet
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_flush_pend) begin
          if (w_in_ready) w_next = FLUSH;
        end else if (use_ready_in[r_idx]) begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: w_next = (w_len == '0) ? IDLE : PACK;
      PACK:    if (w_take && r_rem <= REM_W) w_next = IDLE;
      FLUSH:   if (w_flush_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
      r_rem <= '0;
      r_flush_pend <= 1'b0;
      r_ack <= '0;
      for (int b = 0; b < REC_BYTES; b++) r_rec[b] <= 8'h00;
    end else begin
      r_ack <= '0;
      if (r_state == CAPTURE) begin
        r_ack[r_idx] <= 1'b1;
        for (int b = 0; b < REC_BYTES; b++)
          r_rec[b] <= use_data_in[(int'(r_idx)*REC_BYTES + b)*8 +: 8];
        r_rem <= w_len;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else if (w_take) begin
        for (int b = 0; b < REC_BYTES; b++) r_rec[b] <= w_rec_ext[b+W];
        r_rem <= r_rem - REC_LEN_W'(w_cnt);
      end
      if (flush_in)
        r_flush_pend <= 1'b1;
      else if (w_flush && w_flush_done)
        r_flush_pend <= 1'b0;
    end
  end

  byte_packer #(.W(W)) u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_data       (w_bytes),
    .i_cnt        (w_cnt),
    .o_in_ready   (w_in_ready),
    .i_flush      (w_flush),
    .o_flush_done (w_flush_done),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );
endmodule

// File: tb/tb_use_stream_collector.sv
// tb_use_stream_collector: directed vector table plus
// hand sequences for ring order, back-pressure and reset.
module tb_use_stream_collector;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 34;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N*MB*8-1:0] use_data_in = '0;
  logic [N*LW-1:0] use_len_in = '0;
  logic [N-1:0] use_ready_in = '0;
  logic [N-1:0] use_ack_out;
  logic flush_in = 1'b0;
  logic [W*8-1:0] m_axis_tdata;
  logic [W-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic m_axis_tlast;

  always #5 clk = ~clk;

  use_stream_collector dut (
    .clk          (clk),
    .reset        (reset),
    .use_data_in  (use_data_in),
    .use_len_in   (use_len_in),
    .use_ready_in (use_ready_in),
    .use_ack_out  (use_ack_out),
    .flush_in     (flush_in),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  typedef struct {
    int e;
    int len;
    bit fl;
    int nb;
    logic [W-1:0] keep;
    bit last;
    int left;
  } vec_t;

  vec_t tbl [8];
  int checks = 0;
  int failures = 0;
  byte unsigned exp_q [$];
  byte unsigned got_q [$];
  int beats = 0;
  logic [W-1:0] last_keep = '0;
  logic last_last = 1'b0;
  logic toggle_en = 1'b0;
  int salt = 0;
  int elem_salt [N];
  logic stall_prev = 1'b0;
  logic [W*8-1:0] p_data;
  logic [W-1:0] p_keep;
  logic p_last;

  function automatic byte unsigned pat(int e, int b, int s);
    return 8'(e * 37 + b * 5 + s * 11 + 1);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) m_axis_tready = ~m_axis_tready;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_data ||
            m_axis_tkeep !== p_keep || m_axis_tlast !== p_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tkeep,
                   m_axis_tlast, p_data, p_keep, p_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        last_keep = m_axis_tkeep;
        last_last = m_axis_tlast;
        for (int k = 0; k < W; k++)
          if (m_axis_tkeep[k]) got_q.push_back(m_axis_tdata[k*8 +: 8]);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      p_data = m_axis_tdata;
      p_keep = m_axis_tkeep;
      p_last = m_axis_tlast;
    end
  end

  task automatic set_elem(int e, int len);
    for (int b = 0; b < MB; b++)
      use_data_in[(e*MB + b)*8 +: 8] = pat(e, b, salt);
    use_len_in[e*LW +: LW] = LW'(len);
    elem_salt[e] = salt;
    salt++;
  endtask

  task automatic await_ack(int e, int len, output int lat);
    int n;
    lat = 0;
    while (!use_ack_out[e] && lat < 60) begin
      tick();
      lat++;
    end
    chk($sformatf("ack%0d_onehot", e), 64'(use_ack_out), 64'(1) << e);
    n = (len > MB) ? MB : len;
    for (int b = 0; b < n; b++) exp_q.push_back(pat(e, b, elem_salt[e]));
    tick();
    use_ready_in[e] = 1'b0;
    chk($sformatf("ack%0d_pulse", e), 64'(use_ack_out[e]), 64'(0));
  endtask

  task automatic pulse_flush();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
  endtask

  task automatic serve(int e, int len, bit fl, output int lat);
    set_elem(e, len);
    use_ready_in[e] = 1'b1;
    await_ack(e, len, lat);
    if (fl) pulse_flush();
  endtask

  task automatic check_seg(string name, int nb, logic [W-1:0] keep,
                           bit last, int left, int wait_cyc);
    int bad;
    repeat (wait_cyc) tick();
    chk({name, "_beats"}, 64'(beats), 64'(nb));
    if (nb > 0) begin
      chk({name, "_keep"}, 64'(last_keep), 64'(keep));
      chk({name, "_tlast"}, 64'(last_last), 64'(last));
    end
    bad = 0;
    foreach (got_q[i]) begin
      if (exp_q.size() == 0) bad++;
      else if (exp_q.pop_front() != got_q[i]) bad++;
    end
    chk({name, "_bytes_bad"}, 64'(bad), 64'(0));
    chk({name, "_left"}, 64'(exp_q.size()), 64'(left));
    got_q.delete();
    beats = 0;
  endtask

  initial begin
    int lat;
    int seen;
    tbl[0] = '{0, 10, 1'b1, 2, 8'h03, 1'b1, 0};
    tbl[1] = '{1,  0, 1'b0, 0, 8'h00, 1'b0, 0};
    tbl[2] = '{2,  8, 1'b1, 1, 8'hFF, 1'b0, 0};
    tbl[3] = '{3, 34, 1'b1, 5, 8'h03, 1'b1, 0};
    tbl[4] = '{0, 40, 1'b1, 5, 8'h03, 1'b1, 0};
    tbl[5] = '{1,  1, 1'b1, 1, 8'h01, 1'b1, 0};
    tbl[6] = '{2, 17, 1'b0, 2, 8'hFF, 1'b0, 1};
    tbl[7] = '{3,  7, 1'b1, 1, 8'hFF, 1'b0, 0};

    tick();
    tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_tkeep", 64'(m_axis_tkeep), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_ack", 64'(use_ack_out), 64'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      serve(tbl[i].e, tbl[i].len, tbl[i].fl, lat);
      chk($sformatf("row%0d_ack_lat", i), 64'(lat), 64'(2));
      check_seg($sformatf("row%0d", i), tbl[i].nb, tbl[i].keep,
                tbl[i].last, tbl[i].left, 25);
    end

    set_elem(2, 34);
    set_elem(0, 20);
    use_ready_in = 4'b0101;
    await_ack(0, 20, lat);
    seen = 0;
    repeat (10) begin
      tick();
      if (use_ack_out != '0) seen++;
    end
    chk("ring_no_skip", 64'(seen), 64'(0));
    serve(1, 0, 1'b0, lat);
    await_ack(2, 34, lat);
    pulse_flush();
    check_seg("simul", 7, 8'h3F, 1'b1, 0, 30);

    toggle_en = 1'b1;
    serve(3, 18, 1'b0, lat);
    serve(0, 18, 1'b0, lat);
    serve(1, 18, 1'b1, lat);
    repeat (80) tick();
    toggle_en = 1'b0;
    m_axis_tready = 1'b1;
    check_seg("toggle", 7, 8'h3F, 1'b1, 0, 10);

    serve(2, 30, 1'b0, lat);
    pulse_flush();
    check_seg("midflush", 4, 8'h3F, 1'b1, 0, 30);

    m_axis_tready = 1'b0;
    serve(3, 13, 1'b0, lat);
    repeat (10) tick();
    chk("stalled_tvalid", 64'(m_axis_tvalid), 64'(1));
    reset = 1'b1;
    tick();
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("mid_rst_tkeep", 64'(m_axis_tkeep), 64'(0));
    chk("mid_rst_ack", 64'(use_ack_out), 64'(0));
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    beats = 0;
    m_axis_tready = 1'b1;
    serve(0, 8, 1'b0, lat);
    check_seg("post_reset", 1, 8'hFF, 1'b0, 0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/use_stream_collector.md
# use_stream_collector

Downstream collector for the ring of stream elements that each extract one variable-length record: a variable field, a delimiter, then a fixed field. It drains completed records in ring order (element 0, 1, …, N-1, 0, …), matching the token-passing order that produced them. Each record's bytes are packed back-to-back into a DATA_BUS_WIDTH_BYTES-wide AXI4-Stream master. A flush request closes the packet with a partial beat and TLAST.

## Interface
- NUM_ELEMENTS, 4: number of stream elements in the ring.
- DATA_BUS_WIDTH_BYTES, 8: output bus width in bytes, W; must be 2**n.
- MAX_VARIABLEFIELD_LENGTH, 16: maximum variable-field byte count.
- FIXEDFIELD_LENGTH_BYTES, 'h11: fixed-field byte count.
- MAX_USE_BYTES, MAX_VARIABLEFIELD_LENGTH+FIXEDFIELD_LENGTH_BYTES+1 (=34): maximum record length.
- LEN_W, $clog2(MAX_USE_BYTES): width of each record-length field.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- use_data_in  in  NUM_ELEMENTS*MAX_USE_BYTES*8  record bytes. Element e, byte b is at bit offset (e*MAX_USE_BYTES+b)*8, 8 bits wide.
- use_len_in  in  NUM_ELEMENTS*LEN_W  record byte length per element.
- use_ready_in  in  NUM_ELEMENTS  record-complete flag per element; level, held until acked.
- use_ack_out  out  NUM_ELEMENTS  one-cycle acknowledge per element.
- flush_in  in  1  pulse: terminate the current packet.
- m_axis_tdata  out  W*8  output bytes; byte k is at bits [8k+7:8k].
- m_axis_tkeep  out  W  byte enables.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the packet.

## Operation
- Registers:
  - cur_idx: element currently served.
  - rec_buf[MAX_USE_BYTES]: captured record bytes.
  - rec_rem: record bytes still to pack.
  - acc[2W] and acc_cnt (0..2W-1): packing accumulator.
  - flush_pend: latched flush request.
  - Output beat register, which drives m_axis_*.
- State machine:
  - IDLE to CAPTURE when use_ready_in[cur_idx]=1. Ready of any other element is ignored; there is no skipping, so ring order is strict.
  - CAPTURE (1 cycle):
    - use_ack_out[cur_idx]=1.
    - rec_buf <= that element's bytes.
    - rec_rem <= min(use_len_in[cur_idx], MAX_USE_BYTES); longer lengths are clamped to the maximum.
    - cur_idx <= (cur_idx+1) mod NUM_ELEMENTS.
    - Next state is PACK, or IDLE if the length is 0. A length-0 record is acked and emits nothing.
  - PACK, each cycle:
    - If acc_cnt < W after this cycle's emission: append n = min(W, rec_rem) bytes of rec_buf (in order) at acc position acc_cnt, then acc_cnt += n and rec_rem -= n.
    - Go to IDLE when rec_rem reaches 0.
  - FLUSH: entered from IDLE when flush_pend=1 and acc_cnt < W; performs the flush emission, then returns to IDLE.
- Emission:
  - When acc_cnt >= W and the output register is empty (or being accepted this cycle), load acc[W-1:0] into the output register with tkeep all ones. Shift acc down by W; acc_cnt -= W.
  - Flush emission: if acc_cnt > 0, emit acc[acc_cnt-1:0] with tkeep = (1<<acc_cnt)-1 and tlast=1, then set acc_cnt=0. If acc_cnt = 0, the flush is dropped with no beat.
- flush_in:
  - Sets flush_pend in any state.
  - flush_pend is cleared in FLUSH.
  - A flush arriving during a record takes effect only after that record has been fully packed.
- Beats without flush carry tlast=0.

## Timing
- Reset values: use_ack_out=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0. Internally: cur_idx=0, acc_cnt=0, flush_pend=0, state IDLE.
- Reset mid-operation discards partial bytes and any un-accepted beat. No ack is issued in the reset cycle.
- Ack latency: use_ack_out rises on the clock edge after use_ready_in[cur_idx] is sampled high. The element drops ready on the edge after the ack.
- The first beat is valid no earlier than 3 cycles after ready is sampled.
- Throughput: W bytes per cycle while m_axis_tready=1. The IDLE→CAPTURE overhead is 2 cycles per record.
- AXI rules:
  - tdata, tkeep and tlast are stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Back-pressure stalls PACK; acc never overflows 2W.
- Ready seen simultaneously on several elements: only cur_idx is served.

## Structure
- Package use_stream_pkg holds:
  - MAX_USE_BYTES computation, LEN_W.
  - State enum (IDLE, CAPTURE, PACK, FLUSH).
  - byteReg typedef (8-bit byte).
- Sub-module byte_packer (acc, acc_cnt, emission, output register).
  - Inputs: up to W bytes plus a count, and a flush strobe.
  - Output: the AXI master.
  - The top level holds the ring-order FSM and rec_buf.

## Test plan
- Single record of 10 bytes on element 0, then flush:
  - ack[0] pulses once, 2 cycles after ready.
  - Beat 1: tkeep=8'hFF, bytes 0-7.
  - Beat 2: tkeep=8'h03, tlast=1.
- Elements 2 and 0 ready simultaneously, lengths 34 and 20:
  - Element 0 is served first, then 1 (waited on), then 2.
  - Output is 54 bytes packed contiguously in that order.
- Three records of 18 bytes each, m_axis_tready toggling 1/0:
  - 54 bytes arrive with none lost or duplicated.
  - tdata is stable during stalls.
- Length 0 on element 1: ack[1] pulses, no beat is emitted, service moves to element 2.
- flush_in asserted mid-PACK of a 30-byte record: tlast is set on the beat carrying byte 29 (tkeep=8'h3F).
- Reset asserted with 5 bytes in acc and tvalid=1:
  - Next cycle tvalid=0.
  - A new 8-byte record yields exactly one full beat.
